// File: rtl/aes_apb_sequencer_if.sv
// rtl/aes_apb_sequencer_if.sv - APB requester/completer signal bundle for the AES sequencer
interface aes_apb_sequencer_if #(
  parameter int unsigned APB_ADDR_WIDTH = 32
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [2:0]                PSELx;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [31:0]               PWDATA;
  logic [3:0]                PSTRB;
  logic [2:0]                PPROT;
  logic                      PREADY;
  logic                      PSLVERR;
  logic [31:0]               PRDATA;

  modport master (
    output PADDR, PSELx, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PADDR, PSELx, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/aes_apb_sequencer.sv
// rtl/aes_apb_sequencer.sv - APB requester running one AES-128 encryption per req (optional watchdog: AES_SEQ_TIMEOUT_EN)
module aes_apb_sequencer #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter logic [2:0]  AES_PSEL       = 3'b001,
  parameter logic [31:0] AES_BASE       = 32'h0,
  parameter int unsigned POLL_GAP       = 4
`ifdef AES_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       req,
  input  logic                       key_load,
  input  logic [127:0]               key,
  input  logic [127:0]               pt,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [127:0]               ct,
  aes_apb_sequencer_if.master        apb
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_KEY, S_WR_PT, S_WR_CTRL, S_POLL, S_GAP, S_RD_CT, S_FIN
  } state_e;

  state_e                    state_q, state_d;
  logic [1:0]                idx_q, idx_d;
  logic [7:0]                gap_q, gap_d;
  logic [127:0]              key_q, key_d;
  logic [127:0]              pt_q, pt_d;
  logic [95:0]               ctbuf_q, ctbuf_d;
  logic [127:0]              ct_q, ct_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [2:0]                psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic [3:0]                pstrb_q, pstrb_d;

  logic                      go;
  state_e                    go_state;
  logic [1:0]                go_idx;
  logic                      abort;
  logic [31:0]               off;
  logic                      expired;

  function automatic logic [31:0] word_sel(input logic [127:0] d, input logic [1:0] i);
    case (i)
      2'd0:    return d[127:96];
      2'd1:    return d[95:64];
      2'd2:    return d[63:32];
      default: return d[31:0];
    endcase
  endfunction

`ifdef AES_SEQ_TIMEOUT_EN
  // Watchdog spans the whole polling phase; it saturates so the abort waits for any open transfer.
  logic [31:0] tmo_q, tmo_d;
  assign expired = (tmo_q >= 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_WR_CTRL) begin
      tmo_d = 32'd0;
    end else if ((state_q == S_POLL || state_q == S_GAP) && !expired) begin
      tmo_d = tmo_q + 32'd1;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    key_d     = key_q;
    pt_d      = pt_q;
    ctbuf_d   = ctbuf_q;
    ct_d      = ct_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    go        = 1'b0;
    go_state  = S_IDLE;
    go_idx    = 2'd0;
    abort     = 1'b0;
    off       = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          key_d    = key;
          pt_d     = pt;
          busy_d   = 1'b1;
          go       = 1'b1;
          go_state = key_load ? S_WR_KEY : S_WR_PT;
        end
      end
      S_GAP: begin
        if (expired) begin
          abort = 1'b1;
        end else if (gap_q == 8'd0) begin
          go       = 1'b1;
          go_state = S_POLL;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        if (!penable_q) begin
          penable_d = 1'b1;
        end else if (apb.PREADY) begin
          if (apb.PSLVERR) begin
            abort = 1'b1;
          end else begin
            case (state_q)
              S_WR_KEY: begin
                go       = 1'b1;
                go_idx   = idx_q + 2'd1;
                go_state = (idx_q == 2'd3) ? S_WR_PT : S_WR_KEY;
              end
              S_WR_PT: begin
                go       = 1'b1;
                go_idx   = idx_q + 2'd1;
                go_state = (idx_q == 2'd3) ? S_WR_CTRL : S_WR_PT;
              end
              S_WR_CTRL: begin
                go       = 1'b1;
                go_state = S_POLL;
              end
              S_POLL: begin
                if (apb.PRDATA[0]) begin
                  go       = 1'b1;
                  go_state = S_RD_CT;
                end else if (expired) begin
                  abort = 1'b1;
                end else if (POLL_GAP == 0) begin
                  go       = 1'b1;
                  go_state = S_POLL;
                end else begin
                  state_d   = S_GAP;
                  gap_d     = 8'(POLL_GAP - 1);
                  psel_d    = 3'b000;
                  penable_d = 1'b0;
                end
              end
              S_RD_CT: begin
                // ct is published as a whole on the last word so it never shows a partial result.
                if (idx_q == 2'd3) begin
                  ct_d      = {ctbuf_q, apb.PRDATA};
                  done_d    = 1'b1;
                  busy_d    = 1'b0;
                  state_d   = S_FIN;
                  psel_d    = 3'b000;
                  penable_d = 1'b0;
                end else begin
                  case (idx_q)
                    2'd0:    ctbuf_d[95:64] = apb.PRDATA;
                    2'd1:    ctbuf_d[63:32] = apb.PRDATA;
                    default: ctbuf_d[31:0]  = apb.PRDATA;
                  endcase
                  go       = 1'b1;
                  go_idx   = idx_q + 2'd1;
                  go_state = S_RD_CT;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    if (abort) begin
      state_d   = S_FIN;
      err_d     = 1'b1;
      busy_d    = 1'b0;
      psel_d    = 3'b000;
      penable_d = 1'b0;
    end

    // Launch the SETUP phase of the next transfer.
    if (go) begin
      state_d   = go_state;
      idx_d     = go_idx;
      psel_d    = AES_PSEL;
      penable_d = 1'b0;
      pwrite_d  = 1'b1;
      pstrb_d   = 4'hF;
      pwdata_d  = 32'd0;
      case (go_state)
        S_WR_KEY: begin
          off      = {28'd0, go_idx, 2'b00};
          pwdata_d = word_sel(key_d, go_idx);
        end
        S_WR_PT: begin
          off      = 32'h10 + {28'd0, go_idx, 2'b00};
          pwdata_d = word_sel(pt_d, go_idx);
        end
        S_WR_CTRL: begin
          off      = 32'h20;
          pwdata_d = 32'h1;
        end
        S_POLL: begin
          off      = 32'h24;
          pwrite_d = 1'b0;
          pstrb_d  = 4'h0;
        end
        default: begin
          off      = 32'h30 + {28'd0, go_idx, 2'b00};
          pwrite_d = 1'b0;
          pstrb_d  = 4'h0;
        end
      endcase
      paddr_d = APB_ADDR_WIDTH'(AES_BASE + off);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      gap_q     <= 8'd0;
      key_q     <= '0;
      pt_q      <= '0;
      ctbuf_q   <= '0;
      ct_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      paddr_q   <= '0;
      psel_q    <= 3'b000;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= 4'h0;
`ifdef AES_SEQ_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      key_q     <= key_d;
      pt_q      <= pt_d;
      ctbuf_q   <= ctbuf_d;
      ct_q      <= ct_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
`ifdef AES_SEQ_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ct          = ct_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PSELx   = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;
  assign apb.PPROT   = 3'b000;

endmodule
